conv_enc_ctrl: RTL and testbench
================================

Name: conv_enc_ctrl

Overview:
Controller and sequencer for the rate-1/2 convolutional encoder (conv_enc). It loads the two generator masks through the encoder's load_mask/mask handshake and buffers one frame of information bits. It then streams the frame to the encoder contiguously with a zero tail and captures the coded symbol pairs. The encoder has no clock enable, so once a frame starts it must be fed one bit per cycle with no gaps. This block guarantees that.

Parameters:
N, 4, encoder register width (constraint length + 1); matches conv_enc N
FRAME_MAX, 64, maximum information bits per frame (buffer depth)
LEN_W, 7, width of frm_len; must hold FRAME_MAX

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low; 0 = reset
cfg_start  in  1  pulse: load cfg_g0/cfg_g1 into encoder
cfg_g0  in  N  mask 0 generator, leading 1 prepended (e.g. 'o15)
cfg_g1  in  N  mask 1 generator, leading 1 prepended (e.g. 'o17)
cfg_ok  out  1  masks loaded since last reset
frm_start  in  1  pulse: begin frame, samples frm_len
frm_len  in  LEN_W  information bits in frame, 1..FRAME_MAX
in_valid  in  1  input bit valid
in_data  in  1  input information bit
in_ready  out  1  controller accepts bit
out_valid  out  1  out_sym valid (no backpressure)
out_sym  out  2  coded pair {g1 bit, g0 bit}
out_last  out  1  final symbol of frame
busy  out  1  not IDLE
err  out  1  one-cycle pulse on rejected command
enc_reset  out  1  to conv_enc reset; 0 clears history
enc_load_mask  out  2  to conv_enc load_mask
enc_mask  out  N  to conv_enc mask
enc_data_in  out  1  to conv_enc data_in
enc_data_out  in  2  from conv_enc data_out

Behaviour:
- Reset (async, any state): state IDLE, cfg_ok=0, enc_reset=0, enc_load_mask=00, enc_mask=0, enc_data_in=0, in_ready=0, out_valid=0, out_sym=00, out_last=0, busy=0, err=0, bit count cleared.
- All outputs are registered.
- States: IDLE, LD0, LD1, FILL, CLR, RUN, TAIL, DRAIN.
- IDLE: enc_reset=0. cfg_start -> LD0. Otherwise frm_start -> FILL when cfg_ok=1 and 1<=frm_len<=FRAME_MAX; else err=1 and stay in IDLE. If cfg_start and frm_start arrive together, cfg_start wins and frm_start is dropped without err.
- LD0 (1 cycle): enc_mask=cfg_g0 (sampled at cfg_start), enc_load_mask=01 -> LD1.
- LD1 (1 cycle): enc_mask=cfg_g1, enc_load_mask=10 -> IDLE; cfg_ok=1 from the next cycle. Masks are loaded with enc_reset=0; conv_enc retains masks through reset.
- FILL: in_ready=1 and enc_reset=0. Each in_valid&in_ready cycle writes buf[cnt] and increments cnt. Gaps in in_valid are allowed. After frm_len accepts, in_ready drops on the next cycle -> CLR.
- CLR (1 cycle): enc_reset=1, enc_data_in=0; history stays zero and no symbol is captured.
- RUN: enc_data_in=buf[k] on cycle k, k=0..L-1, with no gaps -> TAIL.
- TAIL: N-1 cycles with enc_data_in=0 -> DRAIN.
- DRAIN (1 cycle): captures the last symbol -> IDLE; enc_reset=0 from the next cycle.
- Capture: enc_data_out reflects the bit driven one cycle earlier. out_sym<=enc_data_out with out_valid=1 on every edge following a RUN/TAIL drive cycle.
- Symbol count is L+N-1; out_last accompanies the final symbol.
- Latency: bit k drive -> its symbol on out_sym 2 cycles later.
- cfg_start or frm_start outside IDLE: ignored, no err.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: CONV_ENC_CTRL_TAIL_EN.
- Defined: zero-tail flush as above; L+N-1 symbols per frame.
- Undefined: no TAIL state; RUN goes directly to DRAIN; L symbols; out_last on symbol L; encoder history is left unflushed and is cleared by enc_reset=0 in IDLE.

Test Plan:
1. Config: cfg_g0='o15, cfg_g1='o17, cfg_start -> enc_load_mask 01 with enc_mask=4'b1101 for one cycle, then 10 with 4'b1111 for one cycle, then 00; cfg_ok=1.
2. Frame, TAIL_EN defined, N=4: frm_len=5, bits 1,0,1,1,0 -> out_sym 11,11,01,11,01,01,11,00; out_last on the 8th; 5 bits accepted; in_ready low afterwards. Check against a reference model: data_out[i]=^(mask_i & history).
3. Same frame with in_valid toggling 1,0,0,1,... during FILL -> identical symbol stream, no gaps in out_valid.
4. Errors: frm_start before config, frm_len=0, frm_len=65 -> err pulses once each; state stays IDLE; no encoder activity.
5. Assert reset=0 during RUN -> all outputs at reset values immediately (cfg_ok=0, enc_reset=0); reconfigure plus the test-2 frame yields the test-2 output.
6. Back-to-back frames with cfg_start pulsed during RUN -> cfg_start ignored; second frame output matches the model with history zeroed.
7. Without CONV_ENC_CTRL_TAIL_EN: test-2 stimulus -> 11,11,01,11,01; out_last on the 5th.

Source files
------------

// File: rtl/conv_enc_ctrl.sv
// Mask loader, frame buffer and gap-free bit sequencer for the rate-1/2 conv_enc.
// Define CONV_ENC_CTRL_TAIL_EN to append the N-1 zero tail flush to every frame.
module conv_enc_ctrl #(
   parameter int N         = 4,
   parameter int FRAME_MAX = 64,
   parameter int LEN_W     = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_start,
   input  logic [N-1:0]     cfg_g0,
   input  logic [N-1:0]     cfg_g1,
   output logic             cfg_ok,
   input  logic             frm_start,
   input  logic [LEN_W-1:0] frm_len,
   input  logic             in_valid,
   input  logic             in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [1:0]       out_sym,
   output logic             out_last,
   output logic             busy,
   output logic             err,
   output logic             enc_reset,
   output logic [1:0]       enc_load_mask,
   output logic [N-1:0]     enc_mask,
   output logic             enc_data_in,
   input  logic [1:0]       enc_data_out
);

   localparam int AW = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

   typedef enum logic [2:0] {IDLE, LD0, LD1, FILL, CLR, RUN, TAIL, DRAIN} state_t;

   state_t           state_reg;
   logic [N-1:0]     g1_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic             drv_reg;
   logic             last_reg;
   logic             buf_mem [FRAME_MAX];

   logic wr_en;
   logic len_ok;
   logic last_drive;

   always_comb begin
      wr_en  = (state_reg == FILL) && in_valid && in_ready;
      len_ok = (frm_len != '0) && (frm_len <= LEN_W'(FRAME_MAX));
`ifdef CONV_ENC_CTRL_TAIL_EN
      last_drive = (state_reg == TAIL) && (cnt_reg == LEN_W'(N - 1));
`else
      last_drive = (state_reg == RUN) && (cnt_reg == len_reg);
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         buf_mem[cnt_reg[AW-1:0]] <= in_data;
   end

   // The encoder output lags its input by one cycle, so capture is keyed off a
   // one-cycle-delayed "was driving" flag rather than the current state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         g1_reg        <= '0;
         len_reg       <= '0;
         cnt_reg       <= '0;
         drv_reg       <= 1'b0;
         last_reg      <= 1'b0;
         cfg_ok        <= 1'b0;
         in_ready      <= 1'b0;
         out_valid     <= 1'b0;
         out_sym       <= 2'b00;
         out_last      <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
         enc_reset     <= 1'b0;
         enc_load_mask <= 2'b00;
         enc_mask      <= '0;
         enc_data_in   <= 1'b0;
      end else begin
         err       <= 1'b0;
         drv_reg   <= (state_reg == RUN) || (state_reg == TAIL);
         last_reg  <= last_drive;
         out_valid <= drv_reg;
         out_last  <= drv_reg & last_reg;
         if (drv_reg)
            out_sym <= enc_data_out;

         case (state_reg)
            IDLE: begin
               enc_reset   <= 1'b0;
               enc_data_in <= 1'b0;
               if (cfg_start) begin
                  g1_reg        <= cfg_g1;
                  enc_mask      <= cfg_g0;
                  enc_load_mask <= 2'b01;
                  busy          <= 1'b1;
                  state_reg     <= LD0;
               end else if (frm_start) begin
                  if (cfg_ok && len_ok) begin
                     len_reg   <= frm_len;
                     cnt_reg   <= '0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b1;
                     state_reg <= FILL;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            LD0: begin
               enc_mask      <= g1_reg;
               enc_load_mask <= 2'b10;
               state_reg     <= LD1;
            end
            LD1: begin
               enc_load_mask <= 2'b00;
               cfg_ok        <= 1'b1;
               busy          <= 1'b0;
               state_reg     <= IDLE;
            end
            FILL: begin
               if (wr_en) begin
                  if (cnt_reg == len_reg - LEN_W'(1)) begin
                     cnt_reg     <= '0;
                     in_ready    <= 1'b0;
                     enc_reset   <= 1'b1;
                     enc_data_in <= 1'b0;
                     state_reg   <= CLR;
                  end else begin
                     cnt_reg <= cnt_reg + LEN_W'(1);
                  end
               end
            end
            CLR: begin
               enc_data_in <= buf_mem[cnt_reg[AW-1:0]];
               cnt_reg     <= cnt_reg + LEN_W'(1);
               state_reg   <= RUN;
            end
            RUN: begin
               if (cnt_reg == len_reg) begin
                  enc_data_in <= 1'b0;
`ifdef CONV_ENC_CTRL_TAIL_EN
                  cnt_reg     <= LEN_W'(1);
                  state_reg   <= TAIL;
`else
                  state_reg   <= DRAIN;
`endif
               end else begin
                  enc_data_in <= buf_mem[cnt_reg[AW-1:0]];
                  cnt_reg     <= cnt_reg + LEN_W'(1);
               end
            end
`ifdef CONV_ENC_CTRL_TAIL_EN
            TAIL: begin
               enc_data_in <= 1'b0;
               if (cnt_reg == LEN_W'(N - 1))
                  state_reg <= DRAIN;
               else
                  cnt_reg <= cnt_reg + LEN_W'(1);
            end
`endif
            DRAIN: begin
               enc_reset   <= 1'b0;
               enc_data_in <= 1'b0;
               busy        <= 1'b0;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_enc_ctrl.sv
// Scoreboard bench for conv_enc_ctrl with a behavioural conv_enc attached.
// Expectations follow CONV_ENC_CTRL_TAIL_EN the same way the design does.
module tb_conv_enc_ctrl;

   localparam int N         = 4;
   localparam int FRAME_MAX = 64;
   localparam int LEN_W     = 7;
`ifdef CONV_ENC_CTRL_TAIL_EN
   localparam int TAIL_LEN = N - 1;
`else
   localparam int TAIL_LEN = 0;
`endif

   logic             clk;
   logic             reset;
   logic             cfg_start;
   logic [N-1:0]     cfg_g0;
   logic [N-1:0]     cfg_g1;
   logic             cfg_ok;
   logic             frm_start;
   logic [LEN_W-1:0] frm_len;
   logic             in_valid;
   logic             in_data;
   logic             in_ready;
   logic             out_valid;
   logic [1:0]       out_sym;
   logic             out_last;
   logic             busy;
   logic             err;
   logic             enc_reset;
   logic [1:0]       enc_load_mask;
   logic [N-1:0]     enc_mask;
   logic             enc_data_in;
   logic [1:0]       enc_data_out;

   conv_enc_ctrl #(.N(N), .FRAME_MAX(FRAME_MAX), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .cfg_start(cfg_start), .cfg_g0(cfg_g0), .cfg_g1(cfg_g1), .cfg_ok(cfg_ok),
      .frm_start(frm_start), .frm_len(frm_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_sym(out_sym), .out_last(out_last),
      .busy(busy), .err(err),
      .enc_reset(enc_reset), .enc_load_mask(enc_load_mask), .enc_mask(enc_mask),
      .enc_data_in(enc_data_in), .enc_data_out(enc_data_out)
   );

   // Behavioural encoder: newest bit enters at the MSB, masks survive reset.
   logic [N-1:0] m0_reg, m1_reg, hist_reg;
   always @(posedge clk) begin
      if (enc_load_mask[0]) m0_reg <= enc_mask;
      if (enc_load_mask[1]) m1_reg <= enc_mask;
      if (!enc_reset) hist_reg <= '0;
      else            hist_reg <= {enc_data_in, hist_reg[N-1:1]};
   end
   assign enc_data_out = {^(m1_reg & hist_reg), ^(m0_reg & hist_reg)};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] sb_q[$];
   logic [1:0] hand_sym [8] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00};
   logic [63:0] frame_a = 64'b01101;
   logic [63:0] frame_b = 64'b1001011;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected {last, sym} per valid output and flags gaps.
   initial begin
      logic       open;
      logic [2:0] exp;
      open = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            open = 1'b0;
         end else begin
            if (open) begin
               checks++;
               if (!out_valid) begin
                  errors++;
                  $display("FAIL out_valid_gap: got 0 expected 1");
               end
            end
            if (out_valid) begin
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_sym: got last=%0b sym=%b expected none", out_last, out_sym);
               end else begin
                  exp = sb_q.pop_front();
                  if ({out_last, out_sym} !== exp) begin
                     errors++;
                     $display("FAIL sym: got last=%0b sym=%b expected last=%0b sym=%b",
                              out_last, out_sym, exp[2], exp[1:0]);
                  end else begin
                     $display("sym last=%0b %b ok", out_last, out_sym);
                  end
               end
            end
            open = out_valid && !out_last;
         end
      end
   end

   task automatic push_hand();
      int total;
      total = 5 + TAIL_LEN;
      for (int i = 0; i < total; i++)
         sb_q.push_back({(i == total - 1), hand_sym[i]});
   endtask

   task automatic push_model(input int len, input logic [63:0] bits,
                             input logic [N-1:0] g0, input logic [N-1:0] g1);
      logic [N-1:0] h;
      logic         b;
      int           total;
      h = '0;
      total = len + TAIL_LEN;
      for (int k = 0; k < total; k++) begin
         b = (k < len) ? bits[k] : 1'b0;
         h = {b, h[N-1:1]};
         sb_q.push_back({(k == total - 1), ^(g1 & h), ^(g0 & h)});
      end
   endtask

   task automatic chk_reset();
      chk("rst_cfg_ok", cfg_ok, 0);
      chk("rst_enc_reset", enc_reset, 0);
      chk("rst_load_mask", enc_load_mask, 0);
      chk("rst_enc_mask", enc_mask, 0);
      chk("rst_data_in", enc_data_in, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sym", out_sym, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
   endtask

   task automatic do_cfg(input logic [N-1:0] g0, input logic [N-1:0] g1);
      cfg_g0 = g0;
      cfg_g1 = g1;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("ld0_load_mask", enc_load_mask, 2'b01);
      chk("ld0_mask", enc_mask, g0);
      chk("ld0_busy", busy, 1);
      @(negedge clk);
      chk("ld1_load_mask", enc_load_mask, 2'b10);
      chk("ld1_mask", enc_mask, g1);
      @(negedge clk);
      chk("cfg_load_mask_idle", enc_load_mask, 2'b00);
      chk("cfg_ok", cfg_ok, 1);
      chk("cfg_busy", busy, 0);
      $display("cfg g0=%b g1=%b done", g0, g1);
   endtask

   task automatic err_cmd(input int len);
      frm_len = LEN_W'(len);
      frm_start = 1'b1;
      @(negedge clk);
      frm_start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_in_ready", in_ready, 0);
      chk("err_load_mask", enc_load_mask, 0);
      chk("err_enc_reset", enc_reset, 0);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      $display("rejected frm_len=%0d", len);
   endtask

   // Returns at the negedge where the controller has just entered CLR.
   task automatic send_frame(input int len, input logic [63:0] bits, input bit gappy);
      int i, p, guard;
      logic v, acc;
      frm_len = LEN_W'(len);
      frm_start = 1'b1;
      @(negedge clk);
      frm_start = 1'b0;
      i = 0; p = 0; guard = 0;
      while (i < len && guard < 400) begin
         v = gappy ? (p % 3 == 0) : 1'b1;
         in_valid = v;
         in_data = bits[i];
         acc = v && in_ready;
         p++;
         guard++;
         @(negedge clk);
         if (acc) i++;
      end
      in_valid = 1'b0;
      in_data = 1'b0;
      chk("bits_accepted", i, len);
      chk("in_ready_drop", in_ready, 0);
      $display("frame len=%0d gappy=%0b loaded", len, gappy);
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("frame_done_remaining", sb_q.size(), 0);
      @(negedge clk);
      chk("done_busy", busy, 0);
      chk("done_out_valid", out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      cfg_start = 1'b0; cfg_g0 = '0; cfg_g1 = '0;
      frm_start = 1'b0; frm_len = '0;
      in_valid = 1'b0; in_data = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset();
      reset = 1'b1;
      @(negedge clk);

      err_cmd(5);
      do_cfg(4'o15, 4'o17);
      err_cmd(0);
      err_cmd(65);

      push_hand();
      send_frame(5, frame_a, 1'b0);
      wait_done();

      push_hand();
      send_frame(5, frame_a, 1'b1);
      wait_done();

      // Reset in the middle of RUN, before any symbol has emerged.
      send_frame(5, frame_a, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_reset();
      sb_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_cfg(4'o15, 4'o17);
      push_hand();
      send_frame(5, frame_a, 1'b0);
      wait_done();

      // cfg_start during RUN must be ignored; next frame starts from zero history.
      push_hand();
      send_frame(5, frame_a, 1'b0);
      @(negedge clk);
      cfg_g0 = 4'o11;
      cfg_g1 = 4'o13;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("run_cfg_ignored_mask", enc_load_mask, 0);
      chk("run_busy", busy, 1);
      @(negedge clk);
      chk("run_cfg_ignored_mask2", enc_load_mask, 0);
      cfg_g0 = 4'o15;
      cfg_g1 = 4'o17;
      wait_done();
      push_model(7, frame_b, 4'o15, 4'o17);
      send_frame(7, frame_b, 1'b0);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
